// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access
// sizes, legal lane-mask encodings and the default bus timeout.
package load_store_unit_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // The only lane masks the unit accepts, for loads and stores alike.
    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational load aligner: moves the selected lanes of a bus word down to
// bit 0, then sign- or zero-extends to 32 bits. The legal flag doubles as the
// lane-mask legality check used when a request is accepted.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [3:0]  i_mask,
    input  logic        i_sext,
    output logic [31:0] o_result,
    output logic        o_legal
);

    logic [4:0]  w_shamt;
    lsu_size_t   w_size;
    logic [31:0] w_shifted;

    // Decode the lane mask into byte offset, access width and legality.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case leaves a value unassigned and infers a latch.
        w_shamt = 5'd0;
        w_size  = SZ_WORD;
        o_legal = 1'b0;
        case (i_mask)
            MASK_B0: begin w_shamt = 5'd0;  w_size = SZ_BYTE; o_legal = 1'b1; end
            MASK_B1: begin w_shamt = 5'd8;  w_size = SZ_BYTE; o_legal = 1'b1; end
            MASK_B2: begin w_shamt = 5'd16; w_size = SZ_BYTE; o_legal = 1'b1; end
            MASK_B3: begin w_shamt = 5'd24; w_size = SZ_BYTE; o_legal = 1'b1; end
            MASK_H0: begin w_shamt = 5'd0;  w_size = SZ_HALF; o_legal = 1'b1; end
            MASK_H1: begin w_shamt = 5'd16; w_size = SZ_HALF; o_legal = 1'b1; end
            MASK_W:  begin w_shamt = 5'd0;  w_size = SZ_WORD; o_legal = 1'b1; end
            default: ;
        endcase
    end

    assign w_shifted = i_rdata >> w_shamt;

    // Extend the aligned value to 32 bits according to access width.
    always_comb begin
        o_result = w_shifted;
        case (w_size)
            SZ_BYTE: o_result = {{24{i_sext & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: o_result = {{16{i_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: o_result = w_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access pipeline stage. Passes non-memory results straight through
// with one cycle of latency; for loads/stores it issues a req/ack bus access,
// stalls upstream until the ack (or a timeout), and registers the aligned
// load result into the writeback bundle.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  EX_rd,
    input  logic        EX_rd_vld,
    input  logic [31:0] EX_x_rd,
    input  logic [31:0] EX_MEM_addr,
    input  logic [3:0]  EX_MEM_rden,
    input  logic        EX_MEM_rden_SEXT,
    input  logic [3:0]  EX_MEM_wren,
    input  logic [31:0] EX_MEM_wrdata,
    output logic        stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [4:0]  MEM_rd,
    output logic        MEM_rd_vld,
    output logic [31:0] MEM_x_rd,
    output logic        MEM_bus_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_inc;
    logic        r_sext;
    logic [4:0]  r_rd;
    logic        r_rd_vld;

    logic        w_is_mem;
    logic        w_both_masks;
    logic [3:0]  w_req_mask;
    logic [3:0]  w_align_mask;
    logic [31:0] w_align_result;
    logic        w_align_legal;
    logic        w_legal;
    logic        w_timeout;

    // The byte offset is fully implied by the lane mask, so the address LSBs
    // carry no extra information.
    logic        w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^EX_MEM_addr[1:0];

    assign w_is_mem     = (|EX_MEM_rden) | (|EX_MEM_wren);
    assign w_both_masks = (|EX_MEM_rden) & (|EX_MEM_wren);
    assign w_req_mask   = EX_MEM_rden | EX_MEM_wren;
    assign w_cnt_inc    = r_cnt + 8'd1;

    // One aligner serves both jobs: in IDLE it judges the incoming mask, in
    // WAIT it aligns the returned word using the captured mask.
    assign w_align_mask = (r_state == ST_WAIT) ? dbus_be : w_req_mask;
    assign w_legal      = w_align_legal & ~w_both_masks;

    load_align u_align (
        .i_rdata  (dbus_rdata),
        .i_mask   (w_align_mask),
        .i_sext   (r_sext),
        .o_result (w_align_result),
        .o_legal  (w_align_legal)
    );

    // Next-state, stall and timeout decode.
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem && w_legal) begin
                    stall       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dbus_ack) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_inc == TIMEOUT_C) begin
                    // Releasing stall here lets upstream drop the faulting op.
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture, bus drive, timeout counter and writeback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 8'd0;
            r_sext      <= 1'b0;
            r_rd        <= 5'd0;
            r_rd_vld    <= 1'b0;
            dbus_req    <= 1'b0;
            dbus_we     <= 1'b0;
            dbus_addr   <= 32'd0;
            dbus_be     <= 4'd0;
            dbus_wdata  <= 32'd0;
            MEM_rd      <= 5'd0;
            MEM_rd_vld  <= 1'b0;
            MEM_x_rd    <= 32'd0;
            MEM_bus_err <= 1'b0;
        end else begin
            MEM_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_is_mem) begin
                        MEM_rd     <= EX_rd;
                        MEM_rd_vld <= EX_rd_vld;
                        MEM_x_rd   <= EX_x_rd;
                    end else begin
                        MEM_rd_vld <= 1'b0;
                        if (w_legal) begin
                            r_cnt      <= 8'd0;
                            r_sext     <= EX_MEM_rden_SEXT;
                            r_rd       <= EX_rd;
                            r_rd_vld   <= EX_rd_vld;
                            dbus_req   <= 1'b1;
                            dbus_we    <= |EX_MEM_wren;
                            dbus_addr  <= {EX_MEM_addr[31:2], 2'b00};
                            dbus_be    <= w_req_mask;
                            dbus_wdata <= EX_MEM_wrdata;
                        end else begin
                            MEM_bus_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        if (dbus_we) begin
                            MEM_rd_vld <= 1'b0;
                        end else begin
                            MEM_rd     <= r_rd;
                            MEM_rd_vld <= r_rd_vld;
                            MEM_x_rd   <= w_align_result;
                        end
                    end else if (w_timeout) begin
                        dbus_req    <= 1'b0;
                        MEM_bus_err <= 1'b1;
                        MEM_rd_vld  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: pass-through, loads of each width,
// store hold, timeout, ack-at-timeout, illegal masks and reset mid-access.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  EX_rd;
    logic        EX_rd_vld;
    logic [31:0] EX_x_rd;
    logic [31:0] EX_MEM_addr;
    logic [3:0]  EX_MEM_rden;
    logic        EX_MEM_rden_SEXT;
    logic [3:0]  EX_MEM_wren;
    logic [31:0] EX_MEM_wrdata;
    logic        stall;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [4:0]  MEM_rd;
    logic        MEM_rd_vld;
    logic [31:0] MEM_x_rd;
    logic        MEM_bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .EX_rd            (EX_rd),
        .EX_rd_vld        (EX_rd_vld),
        .EX_x_rd          (EX_x_rd),
        .EX_MEM_addr      (EX_MEM_addr),
        .EX_MEM_rden      (EX_MEM_rden),
        .EX_MEM_rden_SEXT (EX_MEM_rden_SEXT),
        .EX_MEM_wren      (EX_MEM_wren),
        .EX_MEM_wrdata    (EX_MEM_wrdata),
        .stall            (stall),
        .dbus_req         (dbus_req),
        .dbus_we          (dbus_we),
        .dbus_addr        (dbus_addr),
        .dbus_be          (dbus_be),
        .dbus_wdata       (dbus_wdata),
        .dbus_ack         (dbus_ack),
        .dbus_rdata       (dbus_rdata),
        .MEM_rd           (MEM_rd),
        .MEM_rd_vld       (MEM_rd_vld),
        .MEM_x_rd         (MEM_x_rd),
        .MEM_bus_err      (MEM_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] rd, input logic vld, input logic [31:0] x,
                          input logic [31:0] addr, input logic [3:0] rden, input logic sext,
                          input logic [3:0] wren, input logic [31:0] wdata);
        EX_rd            = rd;
        EX_rd_vld        = vld;
        EX_x_rd          = x;
        EX_MEM_addr      = addr;
        EX_MEM_rden      = rden;
        EX_MEM_rden_SEXT = sext;
        EX_MEM_wren      = wren;
        EX_MEM_wrdata    = wdata;
    endtask

    task automatic clear_ex;
        set_ex(5'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req"},    32'(dbus_req),    32'd0);
        check({tag, ".we"},     32'(dbus_we),     32'd0);
        check({tag, ".addr"},   dbus_addr,        32'd0);
        check({tag, ".be"},     32'(dbus_be),     32'd0);
        check({tag, ".wdata"},  dbus_wdata,       32'd0);
        check({tag, ".rd"},     32'(MEM_rd),      32'd0);
        check({tag, ".rd_vld"}, 32'(MEM_rd_vld),  32'd0);
        check({tag, ".x_rd"},   MEM_x_rd,         32'd0);
        check({tag, ".err"},    32'(MEM_bus_err), 32'd0);
        check({tag, ".stall"},  32'(stall),       32'd0);
    endtask

    initial begin
        rst_n      = 1'b1;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'd0;
        clear_ex();
        #1 rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD pass-through
        set_ex(5'd5, 1'b1, 32'h1234, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        #1 check("add.stall0", 32'(stall), 32'd0);
        tick();
        check("add.x_rd",   MEM_x_rd,         32'h1234);
        check("add.rd",     32'(MEM_rd),      32'd5);
        check("add.rd_vld", 32'(MEM_rd_vld),  32'd1);
        check("add.stall1", 32'(stall),       32'd0);

        // LB sign-extend, lane 3, ack in third WAIT cycle
        set_ex(5'd7, 1'b1, 32'hDEAD, 32'h103, 4'b1000, 1'b1, 4'd0, 32'd0);
        #1;
        check("lb.stall_acc", 32'(stall),    32'd1);
        check("lb.req_acc",   32'(dbus_req), 32'd0);
        tick();
        check("lb.req",    32'(dbus_req),   32'd1);
        check("lb.addr",   dbus_addr,       32'h100);
        check("lb.be",     32'(dbus_be),    32'b1000);
        check("lb.we",     32'(dbus_we),    32'd0);
        check("lb.stall1", 32'(stall),      32'd1);
        check("lb.vld_w",  32'(MEM_rd_vld), 32'd0);
        tick();
        check("lb.stall2", 32'(stall), 32'd1);
        tick();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h80FF_0000;
        clear_ex();
        #1 check("lb.stall_ack", 32'(stall), 32'd0);
        tick();
        dbus_ack = 1'b0;
        check("lb.x_rd",   MEM_x_rd,        32'hFFFF_FF80);
        check("lb.rd",     32'(MEM_rd),     32'd7);
        check("lb.rd_vld", 32'(MEM_rd_vld), 32'd1);
        check("lb.req_end", 32'(dbus_req),  32'd0);

        // LHU upper half, ack in first WAIT cycle
        set_ex(5'd9, 1'b1, 32'd0, 32'h102, 4'b1100, 1'b0, 4'd0, 32'd0);
        tick();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h8001_5555;
        clear_ex();
        #1 check("lhu.stall_ack", 32'(stall), 32'd0);
        tick();
        dbus_ack = 1'b0;
        check("lhu.x_rd",   MEM_x_rd,        32'h0000_8001);
        check("lhu.rd",     32'(MEM_rd),     32'd9);
        check("lhu.rd_vld", 32'(MEM_rd_vld), 32'd1);

        // LH sign-extend, lower half
        set_ex(5'd10, 1'b1, 32'd0, 32'h100, 4'b0011, 1'b1, 4'd0, 32'd0);
        tick();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h1234_F00D;
        clear_ex();
        tick();
        dbus_ack = 1'b0;
        check("lh.x_rd", MEM_x_rd, 32'hFFFF_F00D);

        // SB lane 1, bus outputs held while upstream inputs wander
        set_ex(5'd3, 1'b1, 32'd0, 32'h201, 4'd0, 1'b0, 4'b0010, 32'hABAB_ABAB);
        #1 check("sb.stall_acc", 32'(stall), 32'd1);
        tick();
        check("sb.we",    32'(dbus_we), 32'd1);
        check("sb.be",    32'(dbus_be), 32'b0010);
        check("sb.addr",  dbus_addr,    32'h200);
        check("sb.wdata", dbus_wdata,   32'hABAB_ABAB);
        EX_MEM_wrdata = 32'h1111_1111;
        EX_MEM_addr   = 32'h300;
        tick();
        check("sb.wdata_hold", dbus_wdata,    32'hABAB_ABAB);
        check("sb.addr_hold",  dbus_addr,     32'h200);
        check("sb.stall_w",    32'(stall),    32'd1);
        dbus_ack = 1'b1;
        clear_ex();
        tick();
        dbus_ack = 1'b0;
        check("sb.rd_vld", 32'(MEM_rd_vld), 32'd0);
        check("sb.req",    32'(dbus_req),   32'd0);

        // Timeout after 4 WAIT cycles
        set_ex(5'd12, 1'b1, 32'd0, 32'h104, 4'b1111, 1'b0, 4'd0, 32'd0);
        tick();
        check("to.req1",   32'(dbus_req), 32'd1);
        check("to.stall1", 32'(stall),    32'd1);
        tick();
        tick();
        check("to.stall3", 32'(stall), 32'd1);
        tick();
        check("to.stall4", 32'(stall),       32'd0);
        check("to.req4",   32'(dbus_req),    32'd1);
        check("to.err4",   32'(MEM_bus_err), 32'd0);
        clear_ex();
        tick();
        check("to.req_drop", 32'(dbus_req),    32'd0);
        check("to.err",      32'(MEM_bus_err), 32'd1);
        check("to.rd_vld",   32'(MEM_rd_vld),  32'd0);
        tick();
        check("to.err_pulse", 32'(MEM_bus_err), 32'd0);
        // Stray ack in IDLE alongside a pass-through op
        set_ex(5'd4, 1'b1, 32'h55, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hFFFF_FFFF;
        #1 check("stray.stall", 32'(stall), 32'd0);
        tick();
        dbus_ack = 1'b0;
        check("stray.x_rd",   MEM_x_rd,         32'h55);
        check("stray.rd_vld", 32'(MEM_rd_vld),  32'd1);
        check("stray.req",    32'(dbus_req),    32'd0);
        check("stray.err",    32'(MEM_bus_err), 32'd0);

        // Ack arriving in the cycle the counter would time out
        set_ex(5'd6, 1'b1, 32'd0, 32'h100, 4'b0001, 1'b0, 4'd0, 32'd0);
        tick();
        tick();
        tick();
        tick();
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h0000_00FE;
        clear_ex();
        #1 check("edge.stall", 32'(stall), 32'd0);
        tick();
        dbus_ack = 1'b0;
        check("edge.x_rd",   MEM_x_rd,         32'h0000_00FE);
        check("edge.rd_vld", 32'(MEM_rd_vld),  32'd1);
        check("edge.err",    32'(MEM_bus_err), 32'd0);

        // Illegal masks: 0101, then rden and wren both set
        set_ex(5'd8, 1'b1, 32'h77, 32'h100, 4'b0101, 1'b0, 4'd0, 32'd0);
        #1 check("ill.stall", 32'(stall), 32'd0);
        tick();
        check("ill.err",    32'(MEM_bus_err), 32'd1);
        check("ill.req",    32'(dbus_req),    32'd0);
        check("ill.rd_vld", 32'(MEM_rd_vld),  32'd0);
        set_ex(5'd8, 1'b1, 32'h77, 32'h100, 4'b0001, 1'b0, 4'b0010, 32'd0);
        #1 check("both.stall", 32'(stall), 32'd0);
        tick();
        check("both.err", 32'(MEM_bus_err), 32'd1);
        check("both.req", 32'(dbus_req),    32'd0);
        clear_ex();
        tick();
        check("ill.err_clr", 32'(MEM_bus_err), 32'd0);

        // Reset asserted mid-WAIT
        set_ex(5'd31, 1'b1, 32'hCAFE_BABE, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        tick();
        check("rst.pre_x_rd", MEM_x_rd, 32'hCAFE_BABE);
        set_ex(5'd2, 1'b1, 32'd0, 32'h10C, 4'b1111, 1'b0, 4'd0, 32'h5A5A_5A5A);
        tick();
        check("rst.pre_req",  32'(dbus_req), 32'd1);
        check("rst.pre_addr", dbus_addr,     32'h10C);
        #2;
        rst_n = 1'b0;
        clear_ex();
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst.post_err", 32'(MEM_bus_err), 32'd0);
        check("rst.post_vld", 32'(MEM_rd_vld),  32'd0);
        check("rst.post_req", 32'(dbus_req),    32'd0);

        // Pass-through still works after reset
        set_ex(5'd1, 1'b1, 32'hA5, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
        tick();
        check("post.x_rd",   MEM_x_rd,        32'hA5);
        check("post.rd_vld", 32'(MEM_rd_vld), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
